// File: rtl/layer_ctl_pkg.sv
// Shared types and default command codes for the layer write controller.
package layer_ctl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      DATA  = 3'd2,
      LSEL  = 3'd3,
      LDATA = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [7:0] CMD_ADDR_WR_DEF  = 8'hcc;
   localparam logic [7:0] CMD_DATA_WR_DEF  = 8'hda;
   localparam logic [7:0] CMD_LAYER_WR_DEF = 8'hdb;

endpackage

// File: rtl/edge2en.sv
// Registers a level input and produces one-cycle rise/fall enables, one cycle after the pin.
module edge2en (
   input  logic clk_in,
   input  logic rst_in,
   input  logic sig_in,
   output logic rise_out,
   output logic fall_out
);

   logic sync_r;
   logic prev_r;

   // Idle-high history so a released chip select does not fake a rising edge
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync_r <= 1'b1;
         prev_r <= 1'b1;
      end else begin
         sync_r <= sig_in;
         prev_r <= sync_r;
      end
   end

   assign rise_out = sync_r & ~prev_r;
   assign fall_out = ~sync_r & prev_r;

endmodule

// File: rtl/layer_ctl_gen.sv
// SPI byte stream to layer-RAM write strobes; optional sticky protocol error
// flag enabled with macro LAYER_CTL_ERR_EN.
module layer_ctl_gen
   import layer_ctl_pkg::*;
#(
   parameter int          LAYERS       = 8,
   parameter int          ADDRS        = 64,
   parameter int          COLORS       = 3,
   parameter logic [7:0]  CMD_ADDR_WR  = CMD_ADDR_WR_DEF,
   parameter logic [7:0]  CMD_DATA_WR  = CMD_DATA_WR_DEF,
   parameter logic [7:0]  CMD_LAYER_WR = CMD_LAYER_WR_DEF,
   localparam int         AW           = $clog2(ADDRS)
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              dc_in,
   input  logic              spi_cs_n_in,
   input  logic              byte_rdy_in,
   input  logic [7:0]        byte_data_in,
   output logic              frame_rdy_out,
   output logic [AW-1:0]     wr_addr_out,
   output logic [COLORS:0]   byte_en_out,
   output logic [LAYERS-1:0] layer_en_out,
   output logic              busy_out,
   output logic              err_out
);

   localparam logic [COLORS-1:0] COLOR_MSB = COLORS'(1'b1) << (COLORS - 1);
   localparam logic [LAYERS-1:0] LAYER_MSB = LAYERS'(1'b1) << (LAYERS - 1);

   state_t              state_r, state_nxt;
   logic [AW-1:0]       addr_r, addr_nxt;
   logic [COLORS-1:0]   colour_r, colour_nxt, colour_rot;
   logic                addr_en_r, addr_en_nxt;
   logic [LAYERS-1:0]   layer_r, layer_nxt, layer_rot;
   logic                frame_r, frame_nxt;
   logic                busy_r, busy_nxt;
   logic                err_set;
   logic                restart;
   logic                last_word;
   logic                cs_rise_unused;

   edge2en u_cs_edge (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .sig_in   (spi_cs_n_in),
      .rise_out (cs_rise_unused),
      .fall_out (restart)
   );

   assign last_word = (addr_r == AW'(ADDRS - 1));

   // One-hot right rotations; written as a select so COLORS = 1 stays legal
   always_comb begin
      colour_rot = colour_r[0] ? COLOR_MSB : (colour_r >> 1);
      layer_rot  = layer_r[0]  ? LAYER_MSB : (layer_r >> 1);
   end

   // Next-state and pointer update for commands, data bytes and CS restart
   always_comb begin
      state_nxt   = state_r;
      addr_nxt    = addr_r;
      colour_nxt  = colour_r;
      addr_en_nxt = addr_en_r;
      layer_nxt   = layer_r;
      frame_nxt   = 1'b0;
      err_set     = 1'b0;
      if (restart) begin
         state_nxt   = IDLE;
         addr_nxt    = '0;
         colour_nxt  = '0;
         addr_en_nxt = 1'b0;
         layer_nxt   = '0;
      end else if (byte_rdy_in && !dc_in) begin
         addr_nxt    = '0;
         colour_nxt  = '0;
         addr_en_nxt = 1'b0;
         layer_nxt   = '0;
         case (byte_data_in)
            CMD_ADDR_WR: begin
               state_nxt   = ADDR;
               addr_en_nxt = 1'b1;
               layer_nxt   = '1;
            end
            CMD_DATA_WR: begin
               state_nxt  = DATA;
               colour_nxt = COLOR_MSB;
               layer_nxt  = LAYER_MSB;
            end
            CMD_LAYER_WR: state_nxt = LSEL;
            default:      state_nxt = IDLE;
         endcase
      end else if (byte_rdy_in) begin
         case (state_r)
            ADDR: begin
               if (last_word) begin
                  state_nxt   = DONE;
                  addr_nxt    = '0;
                  addr_en_nxt = 1'b0;
                  layer_nxt   = '0;
                  frame_nxt   = 1'b1;
               end else begin
                  addr_nxt = addr_r + AW'(1'b1);
               end
            end
            DATA, LDATA: begin
               colour_nxt = colour_rot;
               if (colour_r[0] && last_word) begin
                  addr_nxt  = '0;
                  layer_nxt = layer_rot;
                  // A single-layer write ends at its own last word
                  if (layer_r[0] || state_r == LDATA) begin
                     state_nxt  = DONE;
                     colour_nxt = '0;
                     layer_nxt  = '0;
                     frame_nxt  = 1'b1;
                  end else begin
                     state_nxt = state_r;
                  end
               end else if (colour_r[0]) begin
                  addr_nxt = addr_r + AW'(1'b1);
               end else begin
                  addr_nxt = addr_r;
               end
            end
            LSEL: begin
               if (32'(byte_data_in) < LAYERS) begin
                  state_nxt  = LDATA;
                  layer_nxt  = LAYERS'(1'b1) << byte_data_in;
                  colour_nxt = COLOR_MSB;
                  addr_nxt   = '0;
               end else begin
                  state_nxt = DONE;
                  err_set   = 1'b1;
               end
            end
            default: err_set = 1'b1;
         endcase
      end else begin
         state_nxt = state_r;
      end
      busy_nxt = state_nxt inside {ADDR, DATA, LSEL, LDATA};
   end

   // Controller state and registered outputs
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_r   <= IDLE;
         addr_r    <= '0;
         colour_r  <= '0;
         addr_en_r <= 1'b0;
         layer_r   <= '0;
         frame_r   <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt;
         addr_r    <= addr_nxt;
         colour_r  <= colour_nxt;
         addr_en_r <= addr_en_nxt;
         layer_r   <= layer_nxt;
         frame_r   <= frame_nxt;
         busy_r    <= busy_nxt;
      end
   end

`ifdef LAYER_CTL_ERR_EN
   logic err_r;

   // Sticky error, cleared only by reset or a new CS session
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         err_r <= 1'b0;
      end else if (restart) begin
         err_r <= 1'b0;
      end else if (err_set) begin
         err_r <= 1'b1;
      end
   end

   assign err_out = err_r;
`else
   logic err_unused;
   assign err_unused = err_set;
   assign err_out    = 1'b0;
`endif

   // A byte dropped by the CS restart, or a command byte, must not write RAM
   assign layer_en_out  = layer_r & {LAYERS{byte_rdy_in & dc_in & ~restart}};
   assign byte_en_out   = {addr_en_r, colour_r};
   assign wr_addr_out   = addr_r;
   assign frame_rdy_out = frame_r;
   assign busy_out      = busy_r;

endmodule

// File: tb/tb_layer_ctl_gen.sv
// Scoreboard bench for layer_ctl_gen: default build (8x64x3) plus a 4x16x4 instance.
module tb_layer_ctl_gen;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] ben;
      logic [7:0] lay;
      logic       frame;
      logic       err;
   } rec_t;

`ifdef LAYER_CTL_ERR_EN
   localparam bit ERR_ON = 1'b1;
`else
   localparam bit ERR_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, dc, cs_n, rdy1, rdy2;
   logic [7:0] data;

   logic       frame1, busy1, err1;
   logic [5:0] addr1;
   logic [3:0] ben1;
   logic [7:0] lay1;
   logic       frame2, busy2, err2;
   logic [3:0] addr2;
   logic [4:0] ben2;
   logic [3:0] lay2;

   rec_t q1[$];
   rec_t q2[$];
   rec_t cur1, cur2;
   bit   pend1 = 1'b0;
   bit   pend2 = 1'b0;
   bit   exp_err = 1'b0;
   int   total = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   layer_ctl_gen dut1 (
      .clk_in(clk), .rst_in(rst), .dc_in(dc), .spi_cs_n_in(cs_n),
      .byte_rdy_in(rdy1), .byte_data_in(data), .frame_rdy_out(frame1),
      .wr_addr_out(addr1), .byte_en_out(ben1), .layer_en_out(lay1),
      .busy_out(busy1), .err_out(err1)
   );

   layer_ctl_gen #(.LAYERS(4), .ADDRS(16), .COLORS(4)) dut2 (
      .clk_in(clk), .rst_in(rst), .dc_in(dc), .spi_cs_n_in(cs_n),
      .byte_rdy_in(rdy2), .byte_data_in(data), .frame_rdy_out(frame2),
      .wr_addr_out(addr2), .byte_en_out(ben2), .layer_en_out(lay2),
      .busy_out(busy2), .err_out(err2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic rec_t mk(input int a, input int be, input int l, input bit f, input bit e);
      rec_t r;
      r.addr  = a[7:0];
      r.ben   = be[7:0];
      r.lay   = l[7:0];
      r.frame = f;
      r.err   = e;
      return r;
   endfunction

   task automatic push1(input int a, input int be, input int l, input bit f);
      q1.push_back(mk(a, be, l, f, exp_err));
   endtask

   task automatic push2(input int a, input int be, input int l, input bit f);
      q2.push_back(mk(a, be, l, f, 1'b0));
   endtask

   task automatic send(input bit which, input bit d, input logic [7:0] b);
      @(posedge clk);
      #1;
      dc   = d;
      data = b;
      if (which) rdy2 = 1'b1;
      else rdy1 = 1'b1;
      @(posedge clk);
      #1;
      rdy1 = 1'b0;
      rdy2 = 1'b0;
   endtask

   // Monitor: pops an expectation per data strobe, checks frame/err the cycle after
   initial begin
      forever begin
         @(negedge clk);
         if (pend1) begin
            chk("dut1 frame_rdy after byte", {31'd0, frame1}, {31'd0, cur1.frame});
            chk("dut1 err after byte", {31'd0, err1}, {31'd0, cur1.err});
            pend1 = 1'b0;
         end else if (frame1 !== 1'b0) begin
            chk("dut1 stray frame_rdy", {31'd0, frame1}, 32'd0);
         end
         if (pend2) begin
            chk("dut2 frame_rdy after byte", {31'd0, frame2}, {31'd0, cur2.frame});
            chk("dut2 err after byte", {31'd0, err2}, {31'd0, cur2.err});
            pend2 = 1'b0;
         end else if (frame2 !== 1'b0) begin
            chk("dut2 stray frame_rdy", {31'd0, frame2}, 32'd0);
         end
         if (rdy1 && dc) begin
            if (q1.size() == 0) begin
               total++;
               $display("FAIL dut1 scoreboard: got a data strobe, expected none queued");
            end else begin
               cur1 = q1.pop_front();
               chk("dut1 wr_addr", {26'd0, addr1}, {24'd0, cur1.addr});
               chk("dut1 byte_en", {28'd0, ben1}, {24'd0, cur1.ben});
               chk("dut1 layer_en", {24'd0, lay1}, {24'd0, cur1.lay});
               pend1 = 1'b1;
            end
         end
         if (rdy2 && dc) begin
            if (q2.size() == 0) begin
               total++;
               $display("FAIL dut2 scoreboard: got a data strobe, expected none queued");
            end else begin
               cur2 = q2.pop_front();
               chk("dut2 wr_addr", {28'd0, addr2}, {24'd0, cur2.addr});
               chk("dut2 byte_en", {27'd0, ben2}, {24'd0, cur2.ben});
               chk("dut2 layer_en", {28'd0, lay2}, {24'd0, cur2.lay});
               pend2 = 1'b1;
            end
         end
      end
   end

   // Stimulus: directed command/data sequences with hand-derived expectations
   initial begin
      rst = 1'b1; dc = 1'b0; cs_n = 1'b1; rdy1 = 1'b0; rdy2 = 1'b0; data = 8'h00;
      #12;
      chk("reset wr_addr", {26'd0, addr1}, 32'd0);
      chk("reset byte_en", {28'd0, ben1}, 32'd0);
      chk("reset frame_rdy", {31'd0, frame1}, 32'd0);
      chk("reset busy", {31'd0, busy1}, 32'd0);
      chk("reset err", {31'd0, err1}, 32'd0);
      chk("reset dut2 wr_addr", {28'd0, addr2}, 32'd0);
      @(posedge clk);
      #1;
      rst  = 1'b0;
      cs_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Address map to all layers
      send(1'b0, 1'b0, 8'hcc);
      chk("busy in ADDR", {31'd0, busy1}, 32'd1);
      for (int k = 0; k < 64; k++) begin
         push1(k, 8'h08, 8'hff, k == 63);
         send(1'b0, 1'b1, k[7:0]);
      end
      @(posedge clk);
      #1;
      chk("busy after ADDR", {31'd0, busy1}, 32'd0);

      // Full frame: 8 layers x 64 words x 3 colours
      send(1'b0, 1'b0, 8'hda);
      for (int k = 0; k < 1536; k++) begin
         push1((k / 3) % 64, 1 << (2 - k % 3), 8'h80 >> (k / 192), k == 1535);
         send(1'b0, 1'b1, k[7:0]);
      end
      @(posedge clk);
      #1;
      chk("busy after DATA", {31'd0, busy1}, 32'd0);

      // Single layer 5
      send(1'b0, 1'b0, 8'hdb);
      push1(0, 0, 0, 1'b0);
      send(1'b0, 1'b1, 8'h05);
      chk("busy in LDATA", {31'd0, busy1}, 32'd1);
      for (int k = 0; k < 192; k++) begin
         push1(k / 3, 1 << (2 - k % 3), 8'h20, k == 191);
         send(1'b0, 1'b1, k[7:0]);
      end
      @(posedge clk);
      #1;
      chk("busy after LDATA", {31'd0, busy1}, 32'd0);

      // Out-of-range layer index
      send(1'b0, 1'b0, 8'hdb);
      exp_err = ERR_ON;
      push1(0, 0, 0, 1'b0);
      send(1'b0, 1'b1, 8'h09);
      @(posedge clk);
      #1;
      chk("busy after bad index", {31'd0, busy1}, 32'd0);

      // CS restart mid-frame; the error survives the command but not the restart
      send(1'b0, 1'b0, 8'hda);
      for (int k = 0; k < 100; k++) begin
         push1((k / 3) % 64, 1 << (2 - k % 3), 8'h80 >> (k / 192), 1'b0);
         send(1'b0, 1'b1, k[7:0]);
      end
      cs_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cs_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      exp_err = 1'b0;
      chk("restart wr_addr", {26'd0, addr1}, 32'd0);
      chk("restart byte_en", {28'd0, ben1}, 32'd0);
      chk("restart busy", {31'd0, busy1}, 32'd0);
      chk("restart err", {31'd0, err1}, 32'd0);
      exp_err = ERR_ON;
      push1(0, 0, 0, 1'b0);
      send(1'b0, 1'b1, 8'h55);
      send(1'b0, 1'b0, 8'hda);
      for (int k = 0; k < 4; k++) begin
         push1((k / 3) % 64, 1 << (2 - k % 3), 8'h80 >> (k / 192), 1'b0);
         send(1'b0, 1'b1, k[7:0]);
      end

      // Asynchronous reset between clock edges
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async reset wr_addr", {26'd0, addr1}, 32'd0);
      chk("async reset byte_en", {28'd0, ben1}, 32'd0);
      chk("async reset busy", {31'd0, busy1}, 32'd0);
      chk("async reset err", {31'd0, err1}, 32'd0);
      chk("async reset frame_rdy", {31'd0, frame1}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_err = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Second configuration: 4 layers x 16 words x 4 colours = 256 bytes
      send(1'b1, 1'b0, 8'hda);
      chk("dut2 busy in DATA", {31'd0, busy2}, 32'd1);
      for (int k = 0; k < 256; k++) begin
         push2((k / 4) % 16, 1 << (3 - k % 4), 8'h08 >> (k / 64), k == 255);
         send(1'b1, 1'b1, k[7:0]);
      end
      @(posedge clk);
      #1;
      chk("dut2 busy after DATA", {31'd0, busy2}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("dut1 expectations left", q1.size(), 32'd0);
      chk("dut2 expectations left", q2.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/layer_ctl_gen.md
Name: layer_ctl_gen

Overview:
- Parametrised successor to the cube layer/write controller.
- Decodes SPI command/data bytes (dc_in = 1 for data) into RAM write strobes for LAYERS layer RAMs of ADDRS words and COLORS colour bytes each.
- Adds a single-layer write command, a layer-index check, session restart on the falling edge of CS, and a busy flag.
- Sits between the SPI byte receiver and the per-layer frame RAMs.

Parameters:
- LAYERS, 8, number of layer RAMs (≥2).
- ADDRS, 64, words per layer (power of two, ≥2); AW = $clog2(ADDRS).
- COLORS, 3, colour bytes per word (≥1).
- CMD_ADDR_WR, 8'hcc, command: write address map to all layers.
- CMD_DATA_WR, 8'hda, command: write full frame, all layers.
- CMD_LAYER_WR, 8'hdb, command: write one layer; the first data byte is the layer index.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, asynchronous, active-high.
- dc_in  in  1  1 = data byte, 0 = command byte.
- spi_cs_n_in  in  1  SPI chip select; a falling edge restarts the session.
- byte_rdy_in  in  1  one-cycle strobe, byte_data_in valid.
- byte_data_in  in  8  received byte.
- frame_rdy_out  out  1  one-cycle pulse when a write sequence completes.
- wr_addr_out  out  AW  RAM word address for the current byte.
- byte_en_out  out  COLORS+1  {addr_en, colour one-hot}; MSB colour first.
- layer_en_out  out  LAYERS  layer write enables, ANDed combinationally with byte_rdy_in.
- busy_out  out  1  high while in ADDR, DATA, LSEL or LDATA.
- err_out  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset (rst_in high): state=IDLE, wr_addr_out=0, byte_en_out=0, internal layer_en=0, frame_rdy_out=0, busy_out=0, err_out=0.
- Registered pointers give the destination of the next data byte. On byte_rdy_in & dc_in:
  - The consumer writes byte_data_in using the current wr_addr_out, byte_en_out and layer_en_out.
  - Pointers advance on the next clock edge.
- States: IDLE, ADDR, DATA, LSEL, LDATA, DONE.
- Command byte (byte_rdy_in & ~dc_in), accepted in any state, aborts any sequence in progress and clears wr_addr to 0:
  - CMD_ADDR_WR -> ADDR. addr_en=1, colour=0, layer_en all ones.
  - CMD_DATA_WR -> DATA. addr_en=0, colour=1<<(COLORS-1), layer_en=1<<(LAYERS-1).
  - CMD_LAYER_WR -> LSEL. All enables 0.
  - Unknown command -> IDLE, enables 0.
- ADDR: each data byte increments wr_addr. The byte at wr_addr=ADDRS-1 -> DONE, wr_addr wraps to 0, layer_en=0.
- DATA:
  - Colour one-hot rotates right on each byte.
  - On a byte with colour bit0 set, wr_addr increments.
  - When colour bit0 is set and wr_addr=ADDRS-1, wr_addr wraps to 0 and layer_en rotates right.
  - If layer bit0 is also set -> DONE.
- LSEL: the data byte is the layer index.
  - Index < LAYERS -> LDATA, layer_en=1<<index, colour=MSB, wr_addr=0.
  - Index ≥ LAYERS -> DONE with error. This byte drives no layer_en.
- LDATA: same as DATA, but the last word of the selected layer -> DONE. There is no layer rotation.
- frame_rdy_out is registered. It pulses 1 cycle after the final byte of ADDR, DATA or LDATA. It never pulses on the LSEL error path.
- Data byte in IDLE or DONE: ignored, error flagged, no enables.
- spi_cs_n_in falling edge (detected via edge2en, 1 cycle after the pin): state -> IDLE, wr_addr=0, enables 0, err cleared.
  - If this coincides with byte_rdy_in, the restart wins and the byte is dropped.
- A command in the same cycle as the final data byte cannot occur, because byte_rdy_in is one strobe per byte.

Optional Feature:
- Macro LAYER_CTL_ERR_EN.
- Defined:
  - err_out is set by a data byte in IDLE or DONE, or by a layer index ≥ LAYERS.
  - err_out is held until a CS falling edge or reset.
  - A command does not clear it.
- Undefined: err_out tied 0, no error register. All other behaviour is identical.

Decomposition:
- Package layer_ctl_pkg: state enum state_t {IDLE, ADDR, DATA, LSEL, LDATA, DONE}; default command constants.
- Sub-module: reuse the existing edge2en for CS falling-edge detection. Everything else stays in one module.

Test Plan:
- Defaults; CMD_ADDR_WR then 64 data bytes -> layer_en_out=8'hff on each strobe, wr_addr 0..63. frame_rdy_out pulses once, the cycle after byte 64. busy_out then low.
- CMD_DATA_WR then 1536 bytes:
  - Byte 0: layer 8'h80, byte_en 4'b0100, addr 0.
  - Byte 3: addr 1.
  - Byte 192: layer 8'h40.
  - frame_rdy_out pulses only after byte 1536.
- CMD_LAYER_WR, index 8'h05, 192 bytes -> layer_en_out=8'h20 throughout; frame_rdy_out after byte 192. Index 8'h09 -> err_out=1, no frame_rdy_out, no enables.
- Mid-DATA (byte 100): CS high then low -> state IDLE, addr 0. The next data byte sets err_out (with LAYER_CTL_ERR_EN); a new CMD_DATA_WR restarts at layer 8'h80.
- Mid-frame rst_in pulse -> all outputs 0 asynchronously, no frame_rdy_out. Also rerun the full-frame scenario with LAYERS=4, ADDRS=16, COLORS=4 and check sequence length 256 and the rotation orders.
